// File: rtl/jump_branch_predictor.sv
// Fetch-stage jump/branch predictor with decode-stage resolution.
// Direct-mapped table of tagged targets with saturating direction counters.
module jump_branch_predictor #(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 64,
    parameter int CTR_BITS = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            id_valid,
    input  logic            stall,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pc_plus_four,
    input  logic [XLEN-1:0] rs1,
    input  logic            id_pred_taken,
    input  logic [XLEN-1:0] id_pred_target,
    output logic            takeBranch,
    output logic [XLEN-1:0] outputPC,
    output logic            flush,
    output logic            link_we,
    output logic [XLEN-1:0] link_data,
    output logic [31:0]     mispredict_count
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_JR   = 6'h12;
    localparam logic [5:0] OP_JALR = 6'h13;
    localparam logic [5:0] OP_BEQZ = 6'h04;
    localparam logic [5:0] OP_BNEZ = 6'h05;

    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(1 << (CTR_BITS - 1));

    logic [ENTRIES-1:0]  valid_q, valid_d;
    logic [ENTRIES-1:0]  uncond_q, uncond_d;
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [TAG_W-1:0]    tag_d    [ENTRIES];
    logic [XLEN-1:0]     target_q [ENTRIES];
    logic [XLEN-1:0]     target_d [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
    logic [CTR_BITS-1:0] ctr_d    [ENTRIES];

    logic            take_branch_q, take_branch_d;
    logic [XLEN-1:0] output_pc_q, output_pc_d;
    logic            flush_q, flush_d;
    logic            link_we_q, link_we_d;
    logic [XLEN-1:0] link_data_q, link_data_d;
    logic [31:0]     mp_count_q, mp_count_d;

    // Lookup reads only registered table state, so a same-cycle update is not visible.
    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[XLEN-1:IDX_W+2];

    always_comb begin
        pred_taken  = 1'b0;
        pred_target = '0;
        if (valid_q[if_idx] && (tag_q[if_idx] == if_tag)) begin
            pred_taken  = uncond_q[if_idx] | ctr_q[if_idx][CTR_BITS-1];
            pred_target = target_q[if_idx];
        end
    end

    logic            resolve;
    logic [5:0]      opcode;
    logic            is_ctrl;
    logic            is_table_op;
    logic            is_link;
    logic            act_taken;
    logic [XLEN-1:0] act_target;
    logic [XLEN-1:0] upd_pc;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic            upd_hit;
    logic            unused_pc_bits;

    assign resolve        = id_valid & ~stall;
    assign opcode         = instruction[31:26];
    assign upd_pc         = pc_plus_four - XLEN'(4);
    assign upd_idx        = upd_pc[IDX_W+1:2];
    assign upd_tag        = upd_pc[XLEN-1:IDX_W+2];
    assign upd_hit        = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

    always_comb begin
        is_ctrl     = 1'b1;
        is_table_op = 1'b0;
        is_link     = 1'b0;
        act_taken   = 1'b0;
        act_target  = pc_plus_four + {{(XLEN-16){instruction[15]}}, instruction[15:0]};
        unique case (opcode)
            OP_J, OP_JAL: begin
                is_table_op = 1'b1;
                is_link     = (opcode == OP_JAL);
                act_taken   = 1'b1;
                act_target  = pc_plus_four + {{(XLEN-26){instruction[25]}}, instruction[25:0]};
            end
            OP_JR, OP_JALR: begin
                is_link    = (opcode == OP_JALR);
                act_taken  = 1'b1;
                act_target = rs1;
            end
            OP_BEQZ: begin
                is_table_op = 1'b1;
                act_taken   = (rs1 == '0);
            end
            OP_BNEZ: begin
                is_table_op = 1'b1;
                act_taken   = (rs1 != '0);
            end
            default: is_ctrl = 1'b0;
        endcase
    end

    // Registered resolve outputs; pulses drop on any non-resolve edge, PCs hold.
    always_comb begin
        take_branch_d = 1'b0;
        flush_d       = 1'b0;
        link_we_d     = 1'b0;
        output_pc_d   = output_pc_q;
        link_data_d   = link_data_q;
        mp_count_d    = mp_count_q;
        if (resolve) begin
            take_branch_d = act_taken;
            output_pc_d   = act_taken ? act_target : pc_plus_four;
            flush_d       = (act_taken != id_pred_taken) ||
                            (act_taken && (act_target != id_pred_target));
            if (is_ctrl && is_link) begin
                link_we_d   = 1'b1;
                link_data_d = pc_plus_four;
            end
            if (flush_d && (mp_count_q != 32'hFFFF_FFFF)) begin
                mp_count_d = mp_count_q + 32'd1;
            end
        end
    end

    always_comb begin
        valid_d  = valid_q;
        uncond_d = uncond_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (resolve && is_table_op) begin
            if (upd_hit) begin
                target_d[upd_idx] = act_target;
                if (!uncond_q[upd_idx]) begin
                    if (act_taken && (ctr_q[upd_idx] != CTR_MAX)) begin
                        ctr_d[upd_idx] = ctr_q[upd_idx] + CTR_BITS'(1);
                    end else if (!act_taken && (ctr_q[upd_idx] != '0)) begin
                        ctr_d[upd_idx] = ctr_q[upd_idx] - CTR_BITS'(1);
                    end
                end
            end else if (act_taken) begin
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = act_target;
                uncond_d[upd_idx] = (opcode == OP_J) || (opcode == OP_JAL);
                ctr_d[upd_idx]    = CTR_INIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q       <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= '0;
            end
            take_branch_q <= 1'b0;
            output_pc_q   <= '0;
            flush_q       <= 1'b0;
            link_we_q     <= 1'b0;
            link_data_q   <= '0;
            mp_count_q    <= '0;
        end else begin
            valid_q       <= valid_d;
            uncond_q      <= uncond_d;
            tag_q         <= tag_d;
            target_q      <= target_d;
            ctr_q         <= ctr_d;
            take_branch_q <= take_branch_d;
            output_pc_q   <= output_pc_d;
            flush_q       <= flush_d;
            link_we_q     <= link_we_d;
            link_data_q   <= link_data_d;
            mp_count_q    <= mp_count_d;
        end
    end

    assign takeBranch       = take_branch_q;
    assign outputPC         = output_pc_q;
    assign flush            = flush_q;
    assign link_we          = link_we_q;
    assign link_data        = link_data_q;
    assign mispredict_count = mp_count_q;

endmodule

// File: tb/tb_jump_branch_predictor.sv
// Directed plus randomized checks of jump_branch_predictor against a table-level reference model.
module tb_jump_branch_predictor;
    localparam int XLEN     = 32;
    localparam int ENTRIES  = 64;
    localparam int CTR_BITS = 2;
    localparam int CTR_MAX  = (1 << CTR_BITS) - 1;
    localparam int CTR_INIT = 1 << (CTR_BITS - 1);

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [XLEN-1:0] if_pc = '0;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            id_valid = 1'b0;
    logic            stall = 1'b0;
    logic [31:0]     instruction = '0;
    logic [XLEN-1:0] pc_plus_four = '0;
    logic [XLEN-1:0] rs1 = '0;
    logic            id_pred_taken = 1'b0;
    logic [XLEN-1:0] id_pred_target = '0;
    logic            takeBranch;
    logic [XLEN-1:0] outputPC;
    logic            flush;
    logic            link_we;
    logic [XLEN-1:0] link_data;
    logic [31:0]     mispredict_count;

    jump_branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CTR_BITS(CTR_BITS)) dut (
        .clk(clk), .reset(reset), .if_pc(if_pc), .pred_taken(pred_taken),
        .pred_target(pred_target), .id_valid(id_valid), .stall(stall),
        .instruction(instruction), .pc_plus_four(pc_plus_four), .rs1(rs1),
        .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target),
        .takeBranch(takeBranch), .outputPC(outputPC), .flush(flush),
        .link_we(link_we), .link_data(link_data), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference table: one slot per index, tag kept as the whole-PC quotient.
    bit          m_valid [ENTRIES];
    bit          m_uncond[ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    logic [31:0] m_target[ENTRIES];
    int          m_ctr   [ENTRIES];
    bit          model_ready = 0;

    logic        e_tb, e_flush, e_lwe;
    logic [31:0] e_pc, e_ld, e_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_lookup(input logic [31:0] pc, output logic t, output logic [31:0] tgt);
        int idx;
        idx = (pc / 4) % ENTRIES;
        t   = 1'b0;
        tgt = '0;
        if (m_valid[idx] && m_tag[idx] == pc / (4 * ENTRIES)) begin
            t   = m_uncond[idx] || (m_ctr[idx] >= CTR_INIT);
            tgt = m_target[idx];
        end
    endfunction

    function automatic void m_resolve(input logic rst, input logic vld, input logic stl,
                                      input logic [31:0] ins, input logic [31:0] ppf,
                                      input logic [31:0] r1, input logic ip, input logic [31:0] ipt);
        logic [5:0]  op;
        bit          ctrl, tbl, lnk, tk;
        logic [31:0] tgt, upc;
        int          off16, off26, idx;
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_valid[i] = 0;
                m_ctr[i]   = 0;
            end
            e_tb = 0; e_flush = 0; e_lwe = 0; e_pc = 0; e_ld = 0; e_cnt = 0;
            model_ready = 1;
            return;
        end
        e_tb = 0; e_flush = 0; e_lwe = 0;
        if (!(vld && !stl)) return;
        op    = ins[31:26];
        off16 = $signed(ins[15:0]);
        off26 = $signed(ins[25:0]);
        ctrl = 1; tbl = 0; lnk = 0; tk = 0; tgt = 0;
        case (op)
            6'h02, 6'h03: begin tbl = 1; lnk = (op == 6'h03); tk = 1; tgt = ppf + off26; end
            6'h12, 6'h13: begin lnk = (op == 6'h13); tk = 1; tgt = r1; end
            6'h04: begin tbl = 1; tk = (r1 == 0); tgt = ppf + off16; end
            6'h05: begin tbl = 1; tk = (r1 != 0); tgt = ppf + off16; end
            default: ctrl = 0;
        endcase
        e_tb    = tk;
        e_pc    = tk ? tgt : ppf;
        e_flush = (tk != ip) || (tk && tgt != ipt);
        if (ctrl && lnk) begin
            e_lwe = 1;
            e_ld  = ppf;
        end
        if (e_flush && e_cnt != 32'hFFFF_FFFF) e_cnt = e_cnt + 1;
        if (tbl) begin
            upc = ppf - 4;
            idx = (upc / 4) % ENTRIES;
            if (m_valid[idx] && m_tag[idx] == upc / (4 * ENTRIES)) begin
                m_target[idx] = tgt;
                if (!m_uncond[idx]) begin
                    if (tk) m_ctr[idx] = (m_ctr[idx] < CTR_MAX) ? m_ctr[idx] + 1 : CTR_MAX;
                    else    m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
                end
            end else if (tk) begin
                m_valid[idx]  = 1;
                m_tag[idx]    = upc / (4 * ENTRIES);
                m_target[idx] = tgt;
                m_uncond[idx] = (op == 6'h02) || (op == 6'h03);
                m_ctr[idx]    = CTR_INIT;
            end
        end
    endfunction

    // Called at a negedge; returns at the following negedge after checking registered outputs.
    task automatic step(input logic rst, input logic vld, input logic stl, input logic [31:0] ipc,
                        input logic [31:0] ins, input logic [31:0] ppf, input logic [31:0] r1,
                        input logic ip, input logic [31:0] ipt);
        logic        pt;
        logic [31:0] ptg;
        reset = rst; id_valid = vld; stall = stl; if_pc = ipc; instruction = ins;
        pc_plus_four = ppf; rs1 = r1; id_pred_taken = ip; id_pred_target = ipt;
        #1;
        if (model_ready) begin
            m_lookup(ipc, pt, ptg);
            chk("pred_taken", {31'b0, pred_taken}, {31'b0, pt});
            chk("pred_target", pred_target, ptg);
        end
        m_resolve(rst, vld, stl, ins, ppf, r1, ip, ipt);
        @(posedge clk);
        @(negedge clk);
        chk("takeBranch", {31'b0, takeBranch}, {31'b0, e_tb});
        chk("outputPC", outputPC, e_pc);
        chk("flush", {31'b0, flush}, {31'b0, e_flush});
        chk("link_we", {31'b0, link_we}, {31'b0, e_lwe});
        chk("link_data", link_data, e_ld);
        chk("mispredict_count", mispredict_count, e_cnt);
    endtask

    localparam logic [31:0] BEQZ_10 = {6'h04, 10'h0, 16'h0010};
    localparam logic [31:0] BEQZ_20 = {6'h04, 10'h0, 16'h0020};
    localparam logic [31:0] JAL_M4  = {6'h03, 26'h3FF_FFFC};
    localparam logic [31:0] JR      = {6'h12, 26'h0};
    localparam logic [31:0] NOP     = 32'h0;

    initial begin
        logic [5:0]  ops [7];
        logic [31:0] upc, ipc, ins, r1, ipt;
        logic        ip, vld, stl;
        ops = '{6'h02, 6'h03, 6'h12, 6'h13, 6'h04, 6'h05, 6'h20};
        @(negedge clk);
        step(1, 0, 0, 32'h100, NOP, 32'h0, 32'h0, 0, 32'h0);
        step(0, 0, 0, 32'h100, NOP, 32'h0, 32'h0, 0, 32'h0);
        chk("post_reset_pred", {31'b0, pred_taken}, 32'd0);

        // beqz taken on a miss: allocate weakly taken, mispredict counted
        step(0, 1, 0, 32'h100, BEQZ_10, 32'h104, 32'h0, 0, 32'h0);
        chk("beqz_outpc", outputPC, 32'h114);
        chk("beqz_count", mispredict_count, 32'd1);
        step(0, 0, 0, 32'h100, NOP, 32'h0, 32'h0, 0, 32'h0);
        chk("beqz_pred_taken", {31'b0, pred_taken}, 32'd1);
        chk("beqz_pred_target", pred_target, 32'h114);

        // same beqz resolved not taken twice: counter 2 -> 1 -> 0
        step(0, 1, 0, 32'h100, BEQZ_10, 32'h104, 32'h5, 1, 32'h114);
        chk("nt1_outpc", outputPC, 32'h104);
        chk("nt1_pred", {31'b0, pred_taken}, 32'd0);
        step(0, 1, 0, 32'h100, BEQZ_10, 32'h104, 32'h5, 1, 32'h114);
        chk("nt2_outpc", outputPC, 32'h104);

        // jal with negative offset, then a correctly predicted repeat
        step(0, 1, 0, 32'h200, JAL_M4, 32'h204, 32'h0, 0, 32'h0);
        chk("jal_outpc", outputPC, 32'h200);
        chk("jal_link_data", link_data, 32'h204);
        step(0, 1, 0, 32'h200, JAL_M4, 32'h204, 32'h0, 1, 32'h200);
        chk("jal_flush_hit", {31'b0, flush}, 32'd0);

        // jr: redirect and flush but no allocation
        step(0, 1, 0, 32'h300, JR, 32'h304, 32'h8000, 0, 32'h0);
        chk("jr_outpc", outputPC, 32'h8000);
        step(0, 0, 0, 32'h300, NOP, 32'h0, 32'h0, 0, 32'h0);
        chk("jr_no_alloc", {31'b0, pred_taken}, 32'd0);

        // stalled resolve changes nothing
        step(0, 1, 1, 32'h400, BEQZ_10, 32'h404, 32'h0, 0, 32'h0);
        chk("stall_outpc_hold", outputPC, 32'h8000);
        step(0, 0, 0, 32'h400, NOP, 32'h0, 32'h0, 0, 32'h0);
        chk("stall_no_write", {31'b0, pred_taken}, 32'd0);

        // reset wins over a simultaneous resolve
        step(1, 1, 0, 32'h500, BEQZ_10, 32'h504, 32'h0, 0, 32'h0);
        chk("rst_outpc", outputPC, 32'h0);
        step(0, 0, 0, 32'h200, NOP, 32'h0, 32'h0, 0, 32'h0);
        chk("rst_cleared", {31'b0, pred_taken}, 32'd0);

        // same-cycle lookup and update of one index: old entry now, new entry next cycle
        step(0, 1, 0, 32'h500, BEQZ_20, 32'h504, 32'h0, 0, 32'h0);
        step(0, 0, 0, 32'h500, NOP, 32'h0, 32'h0, 0, 32'h0);
        chk("bypass_next_target", pred_target, 32'h524);

        // random traffic over a small PC window with index aliasing
        for (int n = 0; n < 400; n++) begin
            upc = 32'h1000 + 4 * $urandom_range(0, 7) + 4 * ENTRIES * $urandom_range(0, 1);
            ipc = 32'h1000 + 4 * $urandom_range(0, 7) + 4 * ENTRIES * $urandom_range(0, 1);
            ins = {ops[$urandom_range(0, 6)], 10'($urandom_range(0, 1) ? 0 : $urandom),
                   ($urandom_range(0, 1) ? 16'h0010 : 16'hFFF0)};
            r1  = $urandom_range(0, 1) ? 32'h0 : $urandom;
            vld = ($urandom_range(0, 9) != 0);
            stl = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 9) < 7) m_lookup(upc, ip, ipt);
            else begin
                ip  = 1'($urandom);
                ipt = $urandom;
            end
            step(0, vld, stl, ipc, ins, upc + 4, r1, ip, ipt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/jump_branch_predictor.md
JUMP_BRANCH_PREDICTOR -- requirements
Module: jump_branch_predictor

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath and PC width.
REQ-002 SHALL have parameter ENTRIES, default 64, meaning predictor table depth; power of two, at least 4.
REQ-003 SHALL have parameter CTR_BITS, default 2, meaning saturating counter width.
REQ-004 SHALL have ports, in order:
- clk  in  1  clock.
- reset  in  1  reset; one clock; reset is synchronous and active-high.
- if_pc  in  XLEN  fetch PC (lookup).
- pred_taken  out  1  fetch prediction.
- pred_target  out  XLEN  predicted target.
- id_valid  in  1  resolve request.
- stall  in  1  pipeline hold.
- instruction  in  32  decode-stage instruction.
- pc_plus_four  in  XLEN  PC+4 of that instruction.
- rs1  in  XLEN  forwarded rs1 value.
- id_pred_taken  in  1  prediction carried from fetch.
- id_pred_target  in  XLEN  predicted target carried from fetch.
- takeBranch  out  1  registered actual-taken.
- outputPC  out  XLEN  registered redirect PC.
- flush  out  1  registered mispredict.
- link_we  out  1  r31 write enable.
- link_data  out  XLEN  link value.
- mispredict_count  out  32  statistics counter.

Function
REQ-005 SHALL hold ENTRIES entries, each containing valid, tag, target (XLEN), uncond bit and a CTR_BITS counter.
REQ-006 SHALL index entries with idx = if_pc[log2(ENTRIES)+1:2] and tag = remaining upper bits; bits [1:0] are ignored.
REQ-007 SHALL make lookup combinational from registered table state:
- pred_taken = valid AND tag match AND (uncond OR counter MSB).
- pred_target = entry target.
- On no hit: pred_taken=0, pred_target=0.
REQ-008 SHALL decode opcode = instruction[31:26]:
- 0x02 j, 0x03 jal: target pc_plus_four + sign-extended instruction[25:0]; always taken.
- 0x12 jr, 0x13 jalr: target rs1; always taken.
- 0x04 beqz: taken iff rs1 == 0. 0x05 bnez: taken iff rs1 != 0. Target pc_plus_four + sign-extended instruction[15:0].
- Any other opcode: not a control instruction; actual taken=0.
REQ-009 SHALL define resolve = id_valid AND NOT stall; no outputs or table state change without resolve.
REQ-010 SHALL, on the clock edge where resolve is true, register outputs with 1-cycle latency:
- takeBranch = actual taken.
- outputPC = actual target if taken, else pc_plus_four.
- flush = (taken != id_pred_taken) OR (taken AND target != id_pred_target).
REQ-011 SHALL deassert takeBranch, flush and link_we in every cycle following a non-resolve edge; outputPC holds its last value.
REQ-012 SHALL, for jal/jalr, register link_we=1 and link_data=pc_plus_four at the same edge as REQ-010.
REQ-013 SHALL never allocate or update entries for jr, jalr or non-control opcodes.
REQ-014 SHALL handle j/jal/beqz/bnez on table miss as follows:
- Taken: allocate (overwrite) the entry, set valid, tag and target, uncond=1 for j/jal, counter = 2^(CTR_BITS-1) (weakly taken).
- Not taken: no allocation.
REQ-015 SHALL handle these opcodes on table hit as follows:
- Rewrite target.
- Increment counter if taken, decrement if not taken, saturating at 0 and 2^CTR_BITS-1.
- uncond entries leave the counter unchanged.
REQ-016 SHALL compute the table index and tag for a resolve update from pc_plus_four - 4.
REQ-017 SHALL return the pre-update entry for a lookup in the same cycle as an update to the same index; no bypass.
REQ-018 SHALL increment mispredict_count on each edge where the registered flush becomes 1, saturating at 0xFFFFFFFF.
REQ-019 SHALL perform target additions modulo 2^XLEN (wrap, no overflow flag).

Reset
REQ-020 SHALL, on clk edge with reset=1, clear all valid bits and counters and set takeBranch=0, flush=0, link_we=0, outputPC=0, link_data=0, mispredict_count=0.
REQ-021 SHALL give reset priority over a simultaneous resolve; the resolve is discarded and no table write occurs.
REQ-022 SHALL give pred_taken=0 for every if_pc in the cycle after reset.

Verification
REQ-023 SHALL cover: after reset, beqz with rs1=0, pc_plus_four=0x104, imm=0x0010, id_pred_taken=0 -> next cycle takeBranch=1, outputPC=0x114, flush=1, mispredict_count=1; lookup if_pc=0x100 then gives pred_taken=1, pred_target=0x114.
REQ-024 SHALL cover: same beqz resolved not-taken (rs1=5) twice with id_pred_taken=1 -> counter 2->1->0; outputPC=0x104 each time; pred_taken=0 after the first update.
REQ-025 SHALL cover: jal at pc_plus_four=0x204, name=0x3FFFFFC (-4) -> outputPC=0x200, link_we=1, link_data=0x204, entry uncond; a later matching prediction gives flush=0.
REQ-026 SHALL cover: jr with rs1=0x8000, id_pred_taken=0 -> outputPC=0x8000, flush=1, no table entry allocated.
REQ-027 SHALL cover: resolve with stall=1 -> no output change, no table write; resolve with reset=1 -> all outputs 0 next cycle.
REQ-028 SHALL cover: same-cycle lookup and update of one index returns the old entry, and the new entry the following cycle.
